bit_serializer: RTL and testbench
=================================

Name: bit_serializer

Overview:
Parallel-to-serial converter that feeds the downstream sequence detector one bit per clock. It accepts WIDTH-bit words over a valid/ready handshake and buffers one pending word. It shifts each word out on `data` in the configured bit order. Back-to-back words stream with zero idle cycles between them.

Parameters:
WIDTH, 8, word width in bits; legal range is 2 or more.
MSB_FIRST, 1, 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.
IDLE_LEVEL, 0, value driven on `data` whenever no word is being shifted.

Ports:
clk  input  1  single clock; all logic is on posedge clk.
reset  input  1  synchronous, active-high reset.
in_word  input  WIDTH  parallel word to serialize.
in_valid  input  1  in_word is valid this cycle.
in_ready  output  1  block can accept a word this cycle.
data  output  1  serial bit stream to the detector.
data_valid  output  1  `data` carries a real word bit this cycle.
word_done  output  1  one-cycle pulse, high together with the last bit of each word.

Behaviour:
- Reset, on a synchronous posedge with reset=1:
  - data=IDLE_LEVEL, data_valid=0, word_done=0, in_ready=1.
  - Shifter and pending buffer are empty; bit counter=0; state=IDLE.
  - Reset mid-word abandons both the current word and any pending word, with no partial output.
- Accept: a transfer occurs on a posedge where in_valid && in_ready.
- in_ready = !pending_full. It is a pure function of registers, with no combinational path from in_valid.
- Storage: shifter (WIDTH bits), bit counter ($clog2(WIDTH) bits), pending register plus pending_full flag.
- All outputs are registered.
- States, IDLE:
  - data=IDLE_LEVEL, data_valid=0.
  - On accept, the word loads directly into the shifter, counter=0, next state is SHIFT.
  - The first bit appears on data in the cycle after the accept edge (latency 1).
- States, SHIFT:
  - Each bit is held on data for exactly one cycle with data_valid=1.
  - The counter increments each cycle; the last bit is counter==WIDTH-1, and word_done=1 that cycle.
- Routing an accept during SHIFT:
  - Not on the last bit: the word goes into pending and pending_full is set.
  - On the last bit with pending empty: the word loads straight into the shifter, so the next cycle carries its first bit (zero gap).
- End of the last bit:
  - Pending full: pending moves to the shifter, pending_full clears, state stays SHIFT, and the next cycle carries its first bit.
  - Pending empty with no accept: state goes to IDLE; the next cycle has data=IDLE_LEVEL and data_valid=0.
- A pending move and a new accept cannot coincide, because in_ready=0 while pending is full.
- in_ready rises in the cycle after pending drains, so sustained input yields 100% link utilisation.
- in_word is sampled only on the accept edge; later changes have no effect.
- Bit order is fixed per word at load time from MSB_FIRST. The shifter moves left for MSB-first and right for LSB-first.
- Throughput: one word per WIDTH cycles. Maximum occupancy: one word shifting plus one pending.

Decomposition:
- Package serializer_pkg:
  - typedef enum logic {IDLE, SHIFT} ser_state_t.
  - Function next_bit(word, msb_first), returning the outgoing bit.
- One sub-module, serializer_hold_reg:
  - A one-entry holding register with full flag, parameterised by WIDTH.
  - Ports: clk, reset, wr_en, wr_data, rd_en, rd_data, full.
  - bit_serializer instantiates it for the pending word.

Test Plan:
- Reset check, WIDTH=3, MSB_FIRST=1: assert reset 2 cycles, then hold in_valid=0 for 5 cycles -> data=0, data_valid=0, word_done=0, in_ready=1 throughout.
- Single word: WIDTH=3, accept 3'b101 at edge T -> data=1,0,1 on cycles T+1..T+3; data_valid=1 on those cycles; word_done only at T+3; data=0 and data_valid=0 at T+4.
- Back-to-back: WIDTH=3, in_valid held high with 3'b101 then 3'b110 -> data=1,0,1,1,1,0 with no gap; in_ready=0 while the second word is pending; word_done at bits 3 and 6.
- LSB-first: WIDTH=4, MSB_FIRST=0, accept 4'b0011 -> data=1,1,0,0.
- Reset mid-word: WIDTH=8, accept 8'hA5 and a pending 8'hFF, assert reset after bit 3 -> next cycle data=IDLE_LEVEL, data_valid=0, in_ready=1; 8'hFF is never emitted.
- Backpressure: WIDTH=4, in_valid held high with a new word every cycle -> exactly one word accepted per 4 cycles in steady state, and no word lost or duplicated (scoreboard compare).

Source files
------------

// File: rtl/serializer_pkg.sv
// rtl/serializer_pkg.sv - shared state type and outgoing-bit helper for bit_serializer
package serializer_pkg;

    typedef enum logic {IDLE, SHIFT} ser_state_t;

    // Callers pass the two ends of the word so the helper stays width-agnostic.
    function automatic logic next_bit(input logic msb, input logic lsb, input logic msb_first);
        return msb_first ? msb : lsb;
    endfunction

endpackage

// File: rtl/serializer_hold_reg.sv
// rtl/serializer_hold_reg.sv - one-entry holding register with full flag
module serializer_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full
);

    always_ff @(posedge clk) begin
        if (reset) begin
            full    <= 1'b0;
            rd_data <= '0;
        end else if (wr_en) begin
            full    <= 1'b1;
            rd_data <= wr_data;
        end else if (rd_en) begin
            full    <= 1'b0;
        end
    end

endmodule

// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel-to-serial converter with one pending-word buffer
module bit_serializer
    import serializer_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_word,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             data,
    output logic             data_valid,
    output logic             word_done
);

    localparam int                CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

    ser_state_t       state;
    logic [WIDTH-1:0] shifter;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] pend_word;
    logic             pend_full;

    logic             accept;
    logic             last;
    logic             pend_wr;
    logic             pend_rd;
    logic             load;
    logic [WIDTH-1:0] load_word;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return next_bit(w[WIDTH-1], w[0], MSB_FIRST);
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    assign in_ready  = !pend_full;
    assign accept    = in_valid && in_ready;
    assign last      = (state == SHIFT) && (cnt == LAST);
    assign pend_wr   = accept && (state == SHIFT) && !last;
    assign pend_rd   = last && pend_full;
    assign load      = ((state == IDLE) || last) && (pend_rd || accept);
    assign load_word = pend_rd ? pend_word : in_word;

    serializer_hold_reg #(
        .WIDTH (WIDTH)
    ) u_pending (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (pend_wr),
        .wr_data (in_word),
        .rd_en   (pend_rd),
        .rd_data (pend_word),
        .full    (pend_full)
    );

    // The shifter keeps the bits still to be sent; data holds the bit on the wire now.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            shifter    <= '0;
            cnt        <= '0;
            data       <= IDLE_LEVEL;
            data_valid <= 1'b0;
            word_done  <= 1'b0;
        end else if (load) begin
            state      <= SHIFT;
            shifter    <= advance(load_word);
            cnt        <= '0;
            data       <= first_bit(load_word);
            data_valid <= 1'b1;
            word_done  <= 1'b0;
        end else if ((state == IDLE) || last) begin
            state      <= IDLE;
            cnt        <= '0;
            data       <= IDLE_LEVEL;
            data_valid <= 1'b0;
            word_done  <= 1'b0;
        end else begin
            shifter    <= advance(shifter);
            cnt        <= cnt + 1'b1;
            data       <= first_bit(shifter);
            data_valid <= 1'b1;
            word_done  <= ((cnt + 1'b1) == LAST);
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// tb/tb_bit_serializer.sv - scoreboard bench for bit_serializer (MSB-first W=3 and LSB-first W=4)
module tb_bit_serializer;

    typedef struct {
        logic b;
        logic last;
        int   cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid [2] = '{1'b0, 1'b0};
    logic [7:0] in_word  [2] = '{8'h00, 8'h00};
    logic       in_ready [2];
    logic       data     [2];
    logic       data_valid [2];
    logic       word_done  [2];

    exp_t       sb [2][$];
    byte unsigned feed [2][$];
    int         prev_end  [2] = '{-1, -1};
    int         acc_t     [2] = '{0, 0};
    int         acc_start [2] = '{0, 0};
    int         n_acc     [2] = '{0, 0};
    int         win_acc   [2] = '{0, 0};
    bit         acc_flag  [2] = '{1'b0, 1'b0};
    bit         win = 1'b0;
    int         gap_pct = 0;
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(3), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
        .clk        (clk),
        .reset      (reset),
        .in_word    (in_word[0][2:0]),
        .in_valid   (in_valid[0]),
        .in_ready   (in_ready[0]),
        .data       (data[0]),
        .data_valid (data_valid[0]),
        .word_done  (word_done[0])
    );

    bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_lsb (
        .clk        (clk),
        .reset      (reset),
        .in_word    (in_word[1][3:0]),
        .in_valid   (in_valid[1]),
        .in_ready   (in_ready[1]),
        .data       (data[1]),
        .data_valid (data_valid[1]),
        .word_done  (word_done[1])
    );

    function automatic int wid(input int k);
        return (k == 0) ? 3 : 4;
    endfunction

    function automatic bit msbf(input int k);
        return (k == 0);
    endfunction

    function automatic logic idle_lvl(input int k);
        return (k == 0) ? 1'b0 : 1'b1;
    endfunction

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s inst%0d cyc %0d: got %0h expected %0h", name, k, cyc, act, exp);
        end
    endtask

    // Reference model: every accepted word becomes WIDTH bits on a link that is busy
    // back-to-back, starting no earlier than the cycle after the accept edge.
    always @(posedge clk) begin : model
        int   st;
        int   idx;
        exp_t e;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            acc_flag[k] = 1'b0;
            if (reset) begin
                sb[k].delete();
                prev_end[k]  = -1;
                acc_t[k]     = 0;
                acc_start[k] = 0;
            end else if (in_valid[k] && in_ready[k]) begin
                st = (cyc > prev_end[k] + 1) ? cyc : prev_end[k] + 1;
                for (int i = 0; i < wid(k); i++) begin
                    idx    = msbf(k) ? (wid(k) - 1 - i) : i;
                    e.b    = ((in_word[k] >> idx) & 8'd1) != 8'd0;
                    e.last = (i == wid(k) - 1);
                    e.cyc  = st + i;
                    sb[k].push_back(e);
                end
                prev_end[k]  = st + wid(k) - 1;
                acc_t[k]     = cyc;
                acc_start[k] = st;
                n_acc[k]++;
                acc_flag[k]  = 1'b1;
                if (win) win_acc[k]++;
            end
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        logic exp_rdy;
        if (cyc > 0) begin
            for (int k = 0; k < 2; k++) begin
                exp_rdy = !(cyc >= acc_t[k] && cyc < acc_start[k]);
                check("in_ready", k, in_ready[k], exp_rdy);
                if (sb[k].size() > 0 && sb[k][0].cyc == cyc) begin
                    e = sb[k].pop_front();
                    check("data_valid", k, data_valid[k], 1'b1);
                    check("data", k, data[k], e.b);
                    check("word_done", k, word_done[k], e.last);
                end else begin
                    check("idle_valid", k, data_valid[k], 1'b0);
                    check("idle_data", k, data[k], idle_lvl(k));
                    check("idle_done", k, word_done[k], 1'b0);
                end
            end
        end
    end

    always @(posedge clk) begin : driver
        #2;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                in_valid[k] = 1'b0;
            end else if (!in_valid[k] || acc_flag[k]) begin
                if (feed[k].size() > 0 && $urandom_range(99) >= gap_pct) begin
                    in_word[k]  = feed[k].pop_front();
                    in_valid[k] = 1'b1;
                end else begin
                    in_valid[k] = 1'b0;
                    in_word[k]  = 8'($urandom);
                end
            end
        end
    end

    task automatic drain();
        int n = 0;
        while ((feed[0].size() > 0 || feed[1].size() > 0 || in_valid[0] || in_valid[1] ||
                sb[0].size() > 0 || sb[1].size() > 0) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 2000) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout cyc %0d: got busy expected idle", cyc);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) begin
            feed[0].push_back(8'($urandom));
            feed[1].push_back(8'($urandom));
        end
    endtask

    initial begin
        int base [2];
        int n;

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        feed[0].push_back(8'b101);
        feed[1].push_back(8'b0011);
        drain();

        feed[0].push_back(8'b101);
        feed[0].push_back(8'b110);
        feed[1].push_back(8'b0011);
        feed[1].push_back(8'b1010);
        drain();

        gap_pct = 40;
        fill_random(30);
        drain();

        gap_pct = 0;
        fill_random(40);
        repeat (12) @(posedge clk);
        #1 win = 1'b1;
        win_acc[0] = 0;
        win_acc[1] = 0;
        repeat (24) @(posedge clk);
        #1 win = 1'b0;
        check("throughput", 0, win_acc[0], 24 / wid(0));
        check("throughput", 1, win_acc[1], 24 / wid(1));
        drain();

        base[0] = n_acc[0];
        base[1] = n_acc[1];
        feed[0].push_back(8'b101);
        feed[0].push_back(8'b111);
        feed[1].push_back(8'b0101);
        feed[1].push_back(8'b1111);
        n = 0;
        while ((n_acc[0] < base[0] + 2 || n_acc[1] < base[1] + 2) && n < 20) begin
            @(posedge clk);
            n++;
        end
        check("pending_loaded", 1, n_acc[1] - base[1], 2);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        feed[0].delete();
        feed[1].delete();
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        gap_pct = 20;
        fill_random(10);
        drain();

        for (int k = 0; k < 2; k++) check("sb_empty", k, sb[k].size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
